// File: rtl/n2tl_prb_tracker.sv
// Probe-service tracker: queues TL2N Probe requests in a small FIFO and walks
// each one through cache-read / data-wait / done, driving the ProbeAck header.
module n2tl_prb_tracker #(
  parameter int DEPTH  = 4,
  parameter int SIZE_W = 4,
  parameter int SRC_W  = 26,
  parameter int ADDR_W = 64,
  parameter int TMO_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [SIZE_W-1:0]      b_size,
  input  logic [SRC_W-1:0]       b_source,
  input  logic [ADDR_W-1:0]      b_address,
  input  logic                   b_no_data,
  input  logic [TMO_W-1:0]       tmo_limit,
  input  logic                   prb_displ_gen_ack,
  input  logic                   probe_req_done,
  output logic                   probe_req_ack,
  output logic                   prb_displ_gen_en,
  output logic                   prb_flush_wait,
  output logic                   prb_ack_w_data,
  output logic                   prb_ack_no_data,
  output logic [SIZE_W-1:0]      c_prb_ack_size,
  output logic [SRC_W-1:0]       c_prb_ack_source,
  output logic [ADDR_W-1:0]      c_prb_ack_address,
  output logic                   prb_timeout,
  output logic [7:0]             prb_tmo_cnt,
  output logic [$clog2(DEPTH):0] prb_fifo_cnt,
  output logic                   prb_busy
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_INC = 1;

  typedef struct packed {
    logic              no_data;
    logic [SIZE_W-1:0] size;
    logic [SRC_W-1:0]  source;
    logic [ADDR_W-1:0] address;
  } prb_ent_t;

  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    CACHE_RD = 4'b0010,
    DATA_WT  = 4'b0100,
    DONE     = 4'b1000
  } state_t;

  prb_ent_t         mem [DEPTH];
  prb_ent_t         head;
  logic [PW:0]      wr_ptr, rd_ptr;
  logic             full, empty, push, pop;
  state_t           state;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign full         = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty        = (wr_ptr == rd_ptr);
  assign b_ready      = !full;
  assign push         = b_valid && !full;
  assign pop          = (state == DONE);
  assign head         = mem[rd_ptr[PW-1:0]];
  assign prb_fifo_cnt = wr_ptr - rd_ptr;
  assign prb_busy     = (state != IDLE);
  assign tmo_hit      = (tmo_limit != '0) && (tmo_cnt == tmo_limit - TMO_W'(1));

  always_ff @(posedge clk)
    if (push) mem[wr_ptr[PW-1:0]] <= {b_no_data, b_size, b_source, b_address};

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_INC;
      if (pop)  rd_ptr <= rd_ptr + PTR_INC;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state             <= IDLE;
      tmo_cnt           <= '0;
      probe_req_ack     <= 1'b0;
      prb_displ_gen_en  <= 1'b0;
      prb_flush_wait    <= 1'b0;
      prb_ack_w_data    <= 1'b0;
      prb_ack_no_data   <= 1'b0;
      c_prb_ack_size    <= '0;
      c_prb_ack_source  <= '0;
      c_prb_ack_address <= '0;
      prb_timeout       <= 1'b0;
      prb_tmo_cnt       <= '0;
    end else begin
      probe_req_ack <= 1'b0;
      prb_timeout   <= 1'b0;
      case (state)
        IDLE: if (!empty) begin
          c_prb_ack_size    <= head.size;
          c_prb_ack_source  <= head.source;
          c_prb_ack_address <= head.address;
          probe_req_ack     <= 1'b1;
          prb_displ_gen_en  <= 1'b1;
          prb_ack_no_data   <= head.no_data;
          prb_ack_w_data    <= !head.no_data;
          tmo_cnt           <= '0;
          state             <= CACHE_RD;
        end
        CACHE_RD: begin
          // A done pulse here is dropped; only the ack advances.
          if (prb_displ_gen_ack) begin
            prb_displ_gen_en <= 1'b0;
            prb_flush_wait   <= 1'b1;
            tmo_cnt          <= '0;
            state            <= DATA_WT;
          end else if (tmo_hit) begin
            state <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        DATA_WT: begin
          if (probe_req_done) begin
            prb_flush_wait  <= 1'b0;
            prb_ack_w_data  <= 1'b0;
            prb_ack_no_data <= 1'b0;
            state           <= DONE;
          end else if (tmo_hit) begin
            state <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // Expiry abandons the service: drop every event and log it.
      if ((state == CACHE_RD && !prb_displ_gen_ack && tmo_hit) ||
          (state == DATA_WT && !probe_req_done && tmo_hit)) begin
        prb_displ_gen_en <= 1'b0;
        prb_flush_wait   <= 1'b0;
        prb_ack_w_data   <= 1'b0;
        prb_ack_no_data  <= 1'b0;
        prb_timeout      <= 1'b1;
        if (prb_tmo_cnt != 8'hFF) prb_tmo_cnt <= prb_tmo_cnt + 8'd1;
      end
    end
  end
endmodule

// File: doc/n2tl_prb_tracker.md
# n2tl_prb_tracker

Parametrised probe-service tracker between the TL2N B-channel decoder and the TL logic / OXmgr TX path. It buffers incoming Probe requests in a DEPTH-entry FIFO and serves them one at a time through the cache-read / data-wait / done sequence. It drives the ProbeAck header fields (size, source, address) for the probe in service, stable for the whole service. Additions over the single-probe tracker:
- queuing of back-to-back probes
- a per-probe ack mode
- a service timeout with error reporting

## Interface
Parameters:
- DEPTH, 4: probe FIFO entries; power of 2, ≥2.
- SIZE_W, 4: TL size field width.
- SRC_W, 26: TL source field width.
- ADDR_W, 64: TL address width.
- TMO_W, 16: timeout counter width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_  in  1  asynchronous, active-low reset.
- b_valid  in  1  probe request present (TL2N).
- b_ready  out  1  FIFO can accept; equals !full.
- b_size  in  SIZE_W  probe size.
- b_source  in  SRC_W  probe source.
- b_address  in  ADDR_W  probe address.
- b_no_data  in  1  per-probe ack mode; 1 = ProbeAck without data.
- tmo_limit  in  TMO_W  quasi-static timeout in cycles; 0 disables the timeout.
- prb_displ_gen_ack  in  1  pulse from TL logic: displacement generated.
- probe_req_done  in  1  pulse from TL logic: ProbeAck sent.
- probe_req_ack  out  1  one-cycle pulse at service start.
- prb_displ_gen_en  out  1  event: request displacement generation.
- prb_flush_wait  out  1  event: waiting for flush/ack send.
- prb_ack_w_data  out  1  event: current probe acks with data.
- prb_ack_no_data  out  1  event: current probe acks without data.
- c_prb_ack_size  out  SIZE_W  ProbeAck size of the probe in service.
- c_prb_ack_source  out  SRC_W  ProbeAck source of the probe in service.
- c_prb_ack_address  out  ADDR_W  ProbeAck address of the probe in service.
- prb_timeout  out  1  one-cycle pulse when a service times out.
- prb_tmo_cnt  out  8  saturating count of timeouts.
- prb_fifo_cnt  out  $clog2(DEPTH)+1  FIFO occupancy.
- prb_busy  out  1  high when the FSM is not in IDLE.

## Operation
- **FIFO.** Push on b_valid & b_ready; each entry stores {b_no_data, b_size, b_source, b_address}. Pop happens only in the DONE state. Pointers carry one wrap bit (full = MSBs differ and LSBs equal). When full, b_ready is low even if a pop happens in the same cycle (no push-through). b_* inputs are ignored while b_valid is low.
- **FSM states:** one-hot IDLE, CACHE_RD, DATA_WT, DONE.
- **IDLE.** If the FIFO is not empty:
  - load c_prb_ack_* from the head entry;
  - pulse probe_req_ack;
  - set prb_displ_gen_en;
  - set prb_ack_no_data = head.no_data and prb_ack_w_data = !head.no_data;
  - go to CACHE_RD.
- **CACHE_RD.** On prb_displ_gen_ack: clear prb_displ_gen_en, set prb_flush_wait, go to DATA_WT.
- **DATA_WT.** On probe_req_done: clear prb_flush_wait, prb_ack_w_data and prb_ack_no_data; go to DONE.
- **DONE.** Pop the FIFO and go to IDLE unconditionally.
- **Stray inputs.** prb_displ_gen_ack outside CACHE_RD and probe_req_done outside DATA_WT are ignored. If both pulse together in CACHE_RD, only the ack takes effect; the done is lost and the timeout recovers.
- **Timeout.**
  - The counter clears on entry to CACHE_RD and on entry to DATA_WT, and increments each cycle in CACHE_RD or DATA_WT.
  - When tmo_limit ≠ 0 and counter == tmo_limit−1 with no advancing input that cycle: go to DONE, clear all four event outputs, pulse prb_timeout, increment prb_tmo_cnt (saturates at 255).
  - An advancing input in the same cycle as expiry wins; no timeout is taken.
- **Header stability.** c_prb_ack_* change only on the IDLE→CACHE_RD transition and otherwise hold their last value, including after DONE.
- **Reset** (asynchronous, any state): FSM to IDLE, FIFO emptied, all in-flight probes discarded, counters cleared.

## Timing
- Reset values:
  - b_ready = 1 and prb_fifo_cnt = 0;
  - FSM in IDLE, prb_busy = 0;
  - all of the following at 0: every event and pulse output, c_prb_ack_*, prb_tmo_cnt.
- **Latency to start:** a probe accepted at edge E (FIFO empty, FSM idle) has probe_req_ack, prb_displ_gen_en and c_prb_ack_* valid after edge E+1.
- **Service rhythm:** one cycle per FSM transition. A probe_req_done seen at edge D enters DONE, pops at edge D+1, and the next queued probe starts at edge D+2, so the minimum gap between probe_req_ack pulses is 4 cycles.
- **Event outputs are registered:**
  - prb_displ_gen_en falls the edge after the ack is sampled;
  - prb_flush_wait, prb_ack_w_data and prb_ack_no_data fall the edge after the done is sampled.
- **Timeout latency:** with tmo_limit = T, prb_timeout pulses T cycles after entry to the waiting state.
- prb_fifo_cnt updates the edge after a push or pop.

## Test plan
- **Single probe, data mode.** Push one probe (size=6, source=0x15, addr=0x8000_0040, no_data=0); ack 3 cycles later, done 5 cycles later -> probe_req_ack 1 cycle after accept, fields equal the pushed values, w_data=1 until 1 cycle after done, no_data stays 0.
- **Queue fill.** DEPTH=4, push 5 back-to-back probes while the FSM is stalled in CACHE_RD -> b_ready drops after the 4th push (fifo_cnt=4); the 5th is held off until the first DONE pop; all served in order with matching source values.
- **Mixed modes.** Alternate no_data=1/0 over 4 probes -> ack_no_data/ack_w_data alternate exactly per probe and never overlap.
- **Timeout.** tmo_limit=10, never send ack -> after 10 cycles in CACHE_RD: prb_timeout pulses, displ_gen_en clears, prb_tmo_cnt=1, next probe starts at +2 cycles. Repeat with the ack arriving at cycle 9 -> no timeout.
- **Stray and simultaneous inputs.** probe_req_done pulsed in IDLE and CACHE_RD, ack pulsed in DATA_WT -> no state change; ack+done together in CACHE_RD -> DATA_WT only.
- **Reset mid-service.** Assert reset_ asynchronously in DATA_WT with 3 probes queued -> outputs go to reset values without a clock edge; after release, no probe_req_ack until a new push.
